exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter TAG_W, default 4, reservation-station tag width.
REQ-003 Parameter SLOTS, default 4, max in-flight operations (>=2).
REQ-004 Parameters LD_LAT=2, ADD_LAT=2, SUB_LAT=2, MUL_LAT=6, DIV_LAT=25, cycles from accept to result (each >=1).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  discard all in-flight operations.
REQ-008 issue_valid  in  1  issue request.
REQ-009 issue_ready  out  1  unit can accept the presented issue.
REQ-010 issue_op  in  3  opcode: LOAD=001, ADD=010, SUB=011, MUL=100, DIV=101.
REQ-011 issue_tag  in  TAG_W  destination tag.
REQ-012 issue_a, issue_b  in  DATA_W each  operands.
REQ-013 cdb_valid  out  1  result present on common data bus.
REQ-014 cdb_ready  in  1  bus grant; transfer when cdb_valid && cdb_ready.
REQ-015 cdb_tag  out  TAG_W, cdb_data  out  DATA_W  result tag and value.
REQ-016 illegal_op  out  1  one-cycle pulse on accepted illegal opcode.
REQ-017 inflight  out  $clog2(SLOTS+1)  occupied slot count.
REQ-018 div_busy  out  1  a DIV occupies a slot.

Function
REQ-019 Issue accepted on edge where issue_valid && issue_ready; operation stored in a free slot with countdown = opcode latency and an age stamp.
REQ-020 issue_ready = free slot exists && !(issue_op==DIV && div_busy) && !flush; at most one DIV in flight (non-pipelined divider); LOAD/ADD/SUB/MUL fully pipelined.
REQ-021 Results, computed at accept, truncated to DATA_W: LOAD=a; ADD=a+b (wrap); SUB=a-b (wrap); MUL=low DATA_W of a*b (unsigned); DIV=a/b unsigned, b==0 -> all ones.
REQ-022 Illegal opcodes (000,110,111): issue_ready follows free-slot rule, accepted op occupies no slot, illegal_op high exactly the next cycle.
REQ-023 Latency: op accepted at edge E0 with latency L makes its slot eligible; cdb_valid for it no earlier than the cycle following edge E0+L.
REQ-024 Countdown decrements every cycle, saturates at 0 (done); done slots hold while not granted.
REQ-025 CDB arbitration: among done slots, oldest accepted presents; cdb_tag/cdb_data registered, stable while cdb_valid && !cdb_ready.
REQ-026 On transfer, slot freed at that edge; freed slot reusable by an issue in the same cycle (issue_ready reflects slot freed by current transfer).
REQ-027 Simultaneous issue and transfer: inflight unchanged; inflight = accepted - transferred, never exceeds SLOTS.
REQ-028 flush: on that edge all slots cleared, cdb_valid low next cycle, no issue accepted that cycle, illegal_op cleared; pending transfer in flush cycle still counts as completed.
REQ-029 div_busy drops the edge the DIV transfers or is flushed; a new DIV may be accepted that same cycle.
REQ-030 Age stamps wrap-safe: ordering correct across unlimited issue sequences.

Reset
REQ-031 rst high at an edge: all slots free, cdb_valid=0, cdb_tag=0, cdb_data=0, illegal_op=0, inflight=0, div_busy=0; issue_ready=0 while rst high.
REQ-032 rst asserted mid-operation overrides issue, transfer and flush; no result of pre-reset ops ever appears.

Verification
REQ-033 ADD a=7,b=5,tag=3 at E0, cdb_ready=1 -> cdb_valid,tag=3,data=12 in cycle after E2, one cycle only.
REQ-034 DIV 100/7 tag=1 at E0, then MUL 6*7 tag=2 at E1 -> tag=2 data=42 after E7, then tag=1 data=14 after E25; second DIV at E2 sees issue_ready=0.
REQ-035 SUB 0-1 and DIV 9/0 -> data 0xFFFFFFFF each; opcode 111 -> illegal_op pulse, inflight stays 0, no CDB output.
REQ-036 Four ADDs back-to-back, cdb_ready=0 for 10 cycles -> issue_ready=0 at inflight=4, cdb_valid held on oldest tag with stable data; release -> tags in issue order, one per cycle.
REQ-037 Three MULs in flight, flush pulse -> cdb_valid=0 next cycle, inflight=0, no late results; rst mid-DIV -> div_busy=0, all outputs zero next cycle.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: multi-latency execution unit with slot tracking and oldest-first CDB arbitration
//   clk, rst            : clock, synchronous active-high reset
//   flush               : discard every in-flight operation
//   issue_valid/ready   : issue handshake; issue_op/tag/a/b describe the operation
//   cdb_valid/ready     : result handshake; cdb_tag/cdb_data carry the registered result
//   illegal_op          : one-cycle pulse after an accepted illegal opcode
//   inflight, div_busy  : occupied slot count, divider occupied
module exec_unit #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int SLOTS   = 4,
    parameter int LD_LAT  = 2,
    parameter int ADD_LAT = 2,
    parameter int SUB_LAT = 2,
    parameter int MUL_LAT = 6,
    parameter int DIV_LAT = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [2:0]                 issue_op,
    input  logic [TAG_W-1:0]           issue_tag,
    input  logic [DATA_W-1:0]          issue_a,
    input  logic [DATA_W-1:0]          issue_b,
    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic                       illegal_op,
    output logic [$clog2(SLOTS+1)-1:0] inflight,
    output logic                       div_busy
);
    localparam int CW = $clog2(LD_LAT + ADD_LAT + SUB_LAT + MUL_LAT + DIV_LAT + 1);
    localparam int SW = $clog2(SLOTS);
    localparam int NW = $clog2(SLOTS + 1);

    logic [SLOTS-1:0]  valid, is_div;
    logic [CW-1:0]     cnt [SLOTS];
    // rank = number of older occupied slots; dense 0..occ-1, so ordering never wraps
    logic [SW-1:0]     rank [SLOTS];
    logic [TAG_W-1:0]  tag [SLOTS];
    logic [DATA_W-1:0] res [SLOTS];
    logic [SW-1:0]     cur, free_idx, sel;
    logic [NW-1:0]     occ;
    logic              xfer, have_free, sel_found, legal, op_div, accept;
    logic [CW-1:0]     lat;
    logic [DATA_W-1:0] result;

    assign xfer        = cdb_valid && cdb_ready;
    assign legal       = issue_op != 3'b000 && issue_op < 3'b110;
    assign op_div      = issue_op == 3'b101;
    // a DIV transferring this cycle releases the divider for a new DIV
    assign issue_ready = !rst && !flush && have_free && !(op_div && div_busy && !(xfer && is_div[cur]));
    assign accept      = issue_valid && issue_ready;
    assign inflight    = occ;

    // countdown is loaded with latency-1 so the result registers onto the bus at accept+latency
    assign lat = issue_op == 3'b001 ? CW'(LD_LAT - 1)  :
                 issue_op == 3'b010 ? CW'(ADD_LAT - 1) :
                 issue_op == 3'b011 ? CW'(SUB_LAT - 1) :
                 issue_op == 3'b100 ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);

    assign result = issue_op == 3'b001 ? issue_a :
                    issue_op == 3'b010 ? issue_a + issue_b :
                    issue_op == 3'b011 ? issue_a - issue_b :
                    issue_op == 3'b100 ? issue_a * issue_b :
                    issue_b == '0 ? '1 : issue_a / issue_b;

    always_comb begin
        occ       = '0;
        div_busy  = 1'b0;
        have_free = 1'b0;
        free_idx  = '0;
        sel_found = 1'b0;
        sel       = '0;
        for (int i = 0; i < SLOTS; i++) begin
            occ      = occ + NW'(valid[i]);
            div_busy = div_busy || (valid[i] && is_div[i]);
            if (!have_free && (!valid[i] || (xfer && cur == SW'(i)))) begin
                have_free = 1'b1;
                free_idx  = SW'(i);
            end
            // the slot currently on the bus is never a candidate for the next presentation
            if (valid[i] && cnt[i] == '0 && !(cdb_valid && cur == SW'(i)) &&
                (!sel_found || rank[i] < rank[sel])) begin
                sel_found = 1'b1;
                sel       = SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid      <= '0;
            cdb_valid  <= 1'b0;
            illegal_op <= 1'b0;
            if (rst) begin
                cdb_tag  <= '0;
                cdb_data <= '0;
                cur      <= '0;
            end
        end else begin
            illegal_op <= accept && !legal;
            for (int i = 0; i < SLOTS; i++) begin
                if (valid[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
                if (xfer && rank[i] > rank[cur]) rank[i] <= rank[i] - 1'b1;
            end
            if (xfer) valid[cur] <= 1'b0;
            if (accept && legal) begin
                valid[free_idx]  <= 1'b1;
                is_div[free_idx] <= op_div;
                cnt[free_idx]    <= lat;
                rank[free_idx]   <= SW'(occ - NW'(xfer));
                tag[free_idx]    <= issue_tag;
                res[free_idx]    <= result;
            end
            if (!cdb_valid || xfer) begin
                cdb_valid <= sel_found;
                if (sel_found) begin
                    cdb_tag  <= tag[sel];
                    cdb_data <= res[sel];
                    cur      <= sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed scenarios plus randomized traffic checked against a queue-based model
module tb_exec_unit;
    localparam logic [2:0] LD = 3'b001, ADD = 3'b010, SUB = 3'b011, MUL = 3'b100, DIV = 3'b101;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, issue_valid = 1'b0, issue_ready;
    logic        cdb_valid, cdb_ready = 1'b1, illegal_op, div_busy;
    logic [2:0]  issue_op = 3'b000, inflight;
    logic [3:0]  issue_tag = '0, cdb_tag;
    logic [31:0] issue_a = '0, issue_b = '0, cdb_data;
    int          total = 0, bad = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [2:0]  op;
        int          acc;
        int          lat;
        int          id;
    } ent_t;

    exec_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_tag(issue_tag), .issue_a(issue_a), .issue_b(issue_b),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .illegal_op(illegal_op), .inflight(inflight), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            LD:      return a;
            ADD:     return a + b;
            SUB:     return a - b;
            MUL:     return a * b;
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return op == MUL ? 6 : op == DIV ? 25 : 2;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        issue_valid = v;
        issue_op    = op;
        issue_tag   = t;
        issue_a     = a;
        issue_b     = b;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        cdb_ready = 1'b1;
        drive(0, 3'b000, 0, 0, 0);
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1, ADD, 1, 1, 1);
        #1;
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", issue_ready); end
        step;
        step;
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, illegal_op, inflight, div_busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: v=%b tag=%0d data=%h ill=%b infl=%0d div=%b want all 0",
                     cdb_valid, cdb_tag, cdb_data, illegal_op, inflight, div_busy);
        end
        drive(0, 3'b000, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_add;
        do_reset;
        drive(1, ADD, 3, 7, 5);
        step;
        drive(0, 3'b000, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (cdb_valid !== (k == 2) || (k == 2 && (cdb_tag !== 4'd3 || cdb_data !== 32'd12))) begin
                bad++;
                $display("FAIL add_timing k=%0d: got v=%b tag=%0d data=%0d want v=%b tag=3 data=12", k, cdb_valid, cdb_tag, cdb_data, k == 2);
            end
            step;
        end
    endtask

    task automatic test_div_mul;
        do_reset;
        drive(1, DIV, 1, 100, 7);
        step;
        drive(1, MUL, 2, 6, 7);
        step;
        drive(1, DIV, 5, 50, 5);
        #1;
        total++;
        if (issue_ready !== 1'b0 || div_busy !== 1'b1) begin
            bad++;
            $display("FAIL div_block: got ready=%b busy=%b want ready=0 busy=1", issue_ready, div_busy);
        end
        step;
        drive(0, 3'b000, 0, 0, 0);
        for (int k = 2; k <= 25; k++) begin
            total++;
            if (cdb_valid !== (k == 7 || k == 25) ||
                (k == 7 && (cdb_tag !== 4'd2 || cdb_data !== 32'd42)) ||
                (k == 25 && (cdb_tag !== 4'd1 || cdb_data !== 32'd14))) begin
                bad++;
                $display("FAIL divmul_out k=%0d: got v=%b tag=%0d data=%0d", k, cdb_valid, cdb_tag, cdb_data);
            end
            if (k < 25) step;
        end
        drive(1, DIV, 6, 20, 4);
        #1;
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL div_reissue_ready: got %b want 1", issue_ready); end
        step;
        drive(0, 3'b000, 0, 0, 0);
        total++;
        if (div_busy !== 1'b1 || inflight !== 3'd1 || cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL div_reissue_state: got busy=%b infl=%0d v=%b want 1 1 0", div_busy, inflight, cdb_valid);
        end
    endtask

    task automatic test_edge_values;
        int got;
        do_reset;
        drive(1, 3'b111, 7, 1, 1);
        #1;
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready: got %b want 1", issue_ready); end
        step;
        drive(0, 3'b000, 0, 0, 0);
        total++;
        if (illegal_op !== 1'b1 || inflight !== 3'd0 || cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: got ill=%b infl=%0d v=%b want 1 0 0", illegal_op, inflight, cdb_valid);
        end
        step;
        total++;
        if (illegal_op !== 1'b0 || inflight !== 3'd0 || cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_end: got ill=%b infl=%0d v=%b want 0 0 0", illegal_op, inflight, cdb_valid);
        end
        drive(1, SUB, 4, 0, 1);
        step;
        drive(1, DIV, 5, 9, 0);
        step;
        drive(0, 3'b000, 0, 0, 0);
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            step;
            if (cdb_valid) begin
                total++;
                if (cdb_tag !== (got == 0 ? 4'd4 : 4'd5) || cdb_data !== 32'hFFFF_FFFF) begin
                    bad++;
                    $display("FAIL wrap_result #%0d: got tag=%0d data=%h want tag=%0d data=ffffffff", got, cdb_tag, cdb_data, got == 0 ? 4 : 5);
                end
                got++;
            end
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL wrap_timeout: got %0d results want 2", got); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] et;
        logic [31:0] ed;
        do_reset;
        cdb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, ADD, 4'(8 + i), 32'(i), 100);
            step;
        end
        drive(1, ADD, 12, 50, 50);
        #1;
        total++;
        if (inflight !== 3'd4 || issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_block: got infl=%0d ready=%b want 4 0", inflight, issue_ready);
        end
        drive(0, 3'b000, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 4'd8 || cdb_data !== 32'd100) begin
                bad++;
                $display("FAIL hold k=%0d: got v=%b tag=%0d data=%0d want 1 8 100", k, cdb_valid, cdb_tag, cdb_data);
            end
            step;
        end
        cdb_ready = 1'b1;
        drive(1, ADD, 12, 50, 50);
        #1;
        total++;
        if (issue_ready !== 1'b1 || inflight !== 3'd4) begin
            bad++;
            $display("FAIL free_reuse: got ready=%b infl=%0d want 1 4", issue_ready, inflight);
        end
        step;
        drive(0, 3'b000, 0, 0, 0);
        total++;
        if (inflight !== 3'd4) begin bad++; $display("FAIL swap_inflight: got %0d want 4", inflight); end
        for (int j = 0; j < 4; j++) begin
            et = 4'(9 + j);
            ed = j == 3 ? 32'd100 : 32'(101 + j);
            total++;
            if (cdb_valid !== 1'b1 || cdb_tag !== et || cdb_data !== ed) begin
                bad++;
                $display("FAIL drain_order j=%0d: got v=%b tag=%0d data=%0d want 1 %0d %0d", j, cdb_valid, cdb_tag, cdb_data, et, ed);
            end
            step;
        end
        total++;
        if (cdb_valid !== 1'b0 || inflight !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty: got v=%b infl=%0d want 0 0", cdb_valid, inflight);
        end
    endtask

    task automatic test_flush_reset;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1, MUL, 4'(i), 32'(i + 2), 3);
            step;
        end
        drive(0, 3'b000, 0, 0, 0);
        step;
        flush = 1'b1;
        drive(1, ADD, 9, 1, 1);
        #1;
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        step;
        flush = 1'b0;
        drive(0, 3'b000, 0, 0, 0);
        total++;
        if (cdb_valid !== 1'b0 || inflight !== 3'd0) begin
            bad++;
            $display("FAIL flush_state: got v=%b infl=%0d want 0 0", cdb_valid, inflight);
        end
        for (int k = 0; k < 10; k++) begin
            step;
            total++;
            if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_late k=%0d: got v=%b tag=%0d want v=0", k, cdb_valid, cdb_tag); end
        end
        cdb_ready = 1'b0;
        drive(1, ADD, 14, 3, 4);
        step;
        drive(1, DIV, 13, 1000, 3);
        step;
        drive(0, 3'b000, 0, 0, 0);
        step;
        step;
        step;
        total++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd14 || div_busy !== 1'b1) begin
            bad++;
            $display("FAIL prereset: got v=%b tag=%0d busy=%b want 1 14 1", cdb_valid, cdb_tag, div_busy);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        cdb_ready = 1'b1;
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, illegal_op, inflight, div_busy} !== '0) begin
            bad++;
            $display("FAIL midreset: v=%b tag=%0d data=%h ill=%b infl=%0d div=%b want all 0",
                     cdb_valid, cdb_tag, cdb_data, illegal_op, inflight, div_busy);
        end
        for (int k = 0; k < 30; k++) begin
            step;
            total++;
            if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_late k=%0d: got v=%b tag=%0d want v=0", k, cdb_valid, cdb_tag); end
        end
    endtask

    task automatic test_random;
        ent_t q[$];
        int pres, idx, cyc, nid;
        bit sel, exp_ill, has_div, xfer, acc, pdiv, exp_rdy, drain, lg;
        logic [2:0] op;
        do_reset;
        pres = -1; sel = 1; exp_ill = 0; cyc = 0; nid = 0;
        for (int c = 0; c < 1500; c++) begin
            drain = c >= 1000;
            if (drain && q.size() == 0) break;
            idx = -1;
            if (sel) begin
                foreach (q[k]) if (idx < 0 && cyc >= q[k].acc + q[k].lat) idx = k;
                pres = idx < 0 ? -1 : q[idx].id;
                total++;
                if (cdb_valid !== (idx >= 0) || (idx >= 0 && (cdb_tag !== q[idx].tag || cdb_data !== q[idx].data))) begin
                    bad++;
                    $display("FAIL rnd_present cyc=%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h", cyc, cdb_valid, cdb_tag, cdb_data,
                             idx >= 0, idx >= 0 ? q[idx].tag : 4'd0, idx >= 0 ? q[idx].data : 32'd0);
                end
            end else begin
                foreach (q[k]) if (q[k].id == pres) idx = k;
                total++;
                if (idx < 0 || cdb_valid !== 1'b1 || cdb_tag !== q[idx].tag || cdb_data !== q[idx].data) begin
                    bad++;
                    $display("FAIL rnd_hold cyc=%0d: got v=%b tag=%0d data=%h want held entry %0d", cyc, cdb_valid, cdb_tag, cdb_data, pres);
                    if (idx < 0) pres = -1;
                end
            end
            has_div = 0;
            foreach (q[k]) if (q[k].op == DIV) has_div = 1;
            total++;
            if (inflight !== q.size() || div_busy !== has_div || illegal_op !== exp_ill) begin
                bad++;
                $display("FAIL rnd_state cyc=%0d: got infl=%0d busy=%b ill=%b want %0d %b %b", cyc, inflight, div_busy, illegal_op, q.size(), has_div, exp_ill);
            end
            op = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
            drive(!drain && $urandom_range(0, 4) < 3, op, 4'($urandom), $urandom,
                  $urandom_range(0, 7) == 0 ? 32'd0 : ($urandom_range(0, 1) ? 32'($urandom_range(1, 300)) : $urandom));
            cdb_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            xfer = pres >= 0 && cdb_ready;
            pdiv = xfer && idx >= 0 && q[idx].op == DIV;
            exp_rdy = (q.size() < 4 || xfer) && !(op == DIV && has_div && !pdiv);
            total++;
            if (issue_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d op=%0d: got %b want %b", cyc, op, issue_ready, exp_rdy);
            end
            acc = issue_valid && exp_rdy;
            lg = op >= LD && op <= DIV;
            exp_ill = acc && !lg;
            if (xfer && idx >= 0) begin q.delete(idx); pres = -1; end
            sel = pres < 0;
            if (acc && lg) begin
                q.push_back('{issue_tag, model(op, issue_a, issue_b), op, cyc + 1, lat_of(op), nid});
                nid++;
            end
            step;
            cyc++;
        end
        drive(0, 3'b000, 0, 0, 0);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rnd_drain: %0d entries never delivered", q.size()); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_div_mul;
        test_edge_values;
        test_back_to_back;
        test_flush_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
